// File: rtl/paper_pkg.sv
// Shared opcode and state definitions for the paper processor fetch/execute sequencer.
package paper_pkg;

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_JNO = 2'b01;
  localparam logic [1:0] OP_HLT = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_EXEC    = 3'd2,
    ST_OPERAND = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == ST_FETCH) || (s == ST_EXEC) || (s == ST_OPERAND);
  endfunction

endpackage

// File: rtl/paper_fetch_exec.sv
// Fetch/execute sequencer reading the 4x2-bit instruction ROM (INC, JNO, HLT; 11 is a NOP).
// Define PAPER_STEP_EN to add a `step` input that gates each FETCH for single-stepping.
module paper_fetch_exec
  import paper_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int ACC_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
`ifdef PAPER_STEP_EN
  input  logic              step,
`endif
  output logic [ADDR_W-1:0] addr,
  input  logic [1:0]        data,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf,
  output logic              busy,
  output logic              halted
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        ir;
  logic              fetch_go;

`ifdef PAPER_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  assign addr = pc;

  // busy/halted are registered alongside the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      pc     <= '0;
      ir     <= '0;
      busy   <= 1'b0;
      halted <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (run) begin
            state <= ST_FETCH;
            busy  <= is_busy(ST_FETCH);
          end
        end
        ST_FETCH: begin
          if (fetch_go) begin
            ir    <= data;
            pc    <= pc + ADDR_W'(1);
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          unique case (ir)
            OP_JNO: state <= ST_OPERAND;
            OP_HLT: begin
              state  <= ST_HALT;
              busy   <= is_busy(ST_HALT);
              halted <= 1'b1;
            end
            default: state <= ST_FETCH;
          endcase
        end
        ST_OPERAND: begin
          // pc already points at the operand word; overflow skips it.
          pc    <= ovf ? pc + ADDR_W'(1) : ADDR_W'(data);
          state <= ST_FETCH;
        end
        ST_HALT: ;
        default: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

  // Only INC touches the accumulator/flag; JNO, HLT and the illegal word leave them alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (state == ST_EXEC && ir == OP_INC) begin
      {ovf, acc} <= {1'b0, acc} + (ACC_W+1)'(1);
    end
  end

endmodule
